// File: rtl/mysystem_stream_mux_if.sv
// One Avalon-ST video stream (pixel plus sop/eop framing) with a valid/ready handshake.
// The master drives data/valid/sop/eop and the slave drives ready.
interface mysystem_stream_mux_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sop;
    logic              eop;
    logic              ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/mysystem_stream_mux.sv
// Two-input Avalon-ST video stream mux that switches sources only between frames.
// Define STREAM_MUX_STATS_EN to add the drop_cnt port for discarded selected-input beats.
module mysystem_stream_mux #(
    parameter int DATA_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel,
    mysystem_stream_mux_if.slave   in0,
    mysystem_stream_mux_if.slave   in1,
    mysystem_stream_mux_if.master  out,
    output logic                   active_src
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high.
    // Ready never depends on valid; in IDLE it depends on sop so that stray
    // mid-frame beats are drained while a frame start waits for the output.
    typedef enum logic {IDLE, FWD} state_t;

    state_t            state, state_n;
    logic              sel_q;
    logic [DATA_W-1:0] o_data;
    logic              o_valid, o_sop, o_eop;
    logic              fwd_ready;
    logic              load;
    logic              src_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_valid, s_sop, s_eop;

    assign s_data  = active_src ? in1.data  : in0.data;
    assign s_valid = active_src ? in1.valid : in0.valid;
    assign s_sop   = active_src ? in1.sop   : in0.sop;
    assign s_eop   = active_src ? in1.eop   : in0.eop;

    assign fwd_ready = out.ready || !o_valid;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        src_ready = 1'b0;
        case (state)
            IDLE: begin
                src_ready = s_sop ? fwd_ready : 1'b1;
                if (s_valid && s_sop && fwd_ready) begin
                    load = 1'b1;
                    if (!s_eop) state_n = FWD;
                end
            end
            FWD: begin
                src_ready = fwd_ready;
                if (s_valid && fwd_ready) begin
                    load = 1'b1;
                    if (s_eop) state_n = IDLE;
                end
            end
        endcase
    end

    // The unselected input is always drained so its upstream never stalls.
    assign in0.ready = !reset && (active_src ? 1'b1 : src_ready);
    assign in1.ready = !reset && (active_src ? src_ready : 1'b1);

    assign out.data  = o_data;
    assign out.valid = o_valid;
    assign out.sop   = o_sop;
    assign out.eop   = o_eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= 1'b0;
            active_src <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
        end else begin
            state <= state_n;
            sel_q <= sel;
            // Only re-latch the source while no frame is starting, so a frame
            // accepted in IDLE keeps the source that supplied its sop.
            if (state == IDLE && state_n == IDLE) active_src <= sel_q;
            if (load) begin
                o_data  <= s_data;
                o_valid <= 1'b1;
                o_sop   <= s_sop;
                o_eop   <= s_eop;
            end else if (out.ready && o_valid) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_STATS_EN
    logic discard;

    assign discard = (state == IDLE) && s_valid && !s_sop;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 16'h0000;
        end else if (discard && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mysystem_stream_mux.sv
// Scoreboard bench for mysystem_stream_mux: expected output beats are queued as
// stimulus is driven and compared in order whenever the output handshakes.
module tb_mysystem_stream_mux;

    localparam int DATA_W = 24;
    localparam int W      = DATA_W + 2;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic active_src;
`ifdef STREAM_MUX_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_base;
`endif

    mysystem_stream_mux_if #(.DATA_W(DATA_W)) in0_if ();
    mysystem_stream_mux_if #(.DATA_W(DATA_W)) in1_if ();
    mysystem_stream_mux_if #(.DATA_W(DATA_W)) out_if ();

    mysystem_stream_mux #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .in0        (in0_if),
        .in1        (in1_if),
        .out        (out_if),
        .active_src (active_src)
`ifdef STREAM_MUX_STATS_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int n_vec  = 0;
    int n_fail = 0;
    bit sh[16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("out_beat", 32'({out_if.sop, out_if.eop, out_if.data}), 32'(mon_e));
            end
        end
    end

    // drivers
    task automatic put(input int src, input logic [DATA_W-1:0] d, input logic s,
                       input logic e, input logic v);
        if (src == 0) begin
            in0_if.data = d; in0_if.sop = s; in0_if.eop = e; in0_if.valid = v;
        end else begin
            in1_if.data = d; in1_if.sop = s; in1_if.eop = e; in1_if.valid = v;
        end
    endtask

    task automatic wait_acc(input int src, output int cyc);
        logic acc;
        cyc = 0;
        do begin
            @(negedge clk);
            acc = (src == 0) ? in0_if.ready : in1_if.ready;
            @(posedge clk);
            cyc++;
        end while (!acc && cyc < 100);
        if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
        #1;
    endtask

    task automatic send(input int src, input logic [DATA_W-1:0] d, input logic s,
                        input logic e, input bit expd, output int cyc);
        if (expd) exp_q.push_back({s, e, d});
        put(src, d, s, e, 1'b1);
        wait_acc(src, cyc);
        put(src, d, s, e, 1'b0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int t;
        bit src;

        // reset state, with a frame start pending on input 0
        reset = 1'b1;
        sel = 1'b0;
        out_if.ready = 1'b1;
        put(0, 24'h000001, 1'b1, 1'b0, 1'b1);
        put(1, 24'h000000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in0_ready", 32'(in0_if.ready), 32'd0);
        check_eq("rst_in1_ready", 32'(in1_if.ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_if.valid), 32'd0);
        check_eq("rst_out_data", 32'(out_if.data), 32'd0);
        check_eq("rst_active_src", 32'(active_src), 32'd0);
`ifdef STREAM_MUX_STATS_EN
        check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        put(0, 24'h000000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cycles(2);

        // pass-through on input 0, input 1 drained
        fork
            begin
                int c0;
                for (int i = 0; i < 4; i++)
                    send(0, 24'(32'h100000 + i), i == 0, i == 3, 1'b1, c0);
            end
            begin
                int c1;
                for (int i = 0; i < 4; i++) begin
                    send(1, 24'(32'h200000 + i), i == 0, i == 3, 1'b0, c1);
                    check_eq("unsel_in1_ready", 32'(c1), 32'd1);
                end
            end
        join
        @(negedge clk);
        check_eq("lat_out_valid", 32'(out_if.valid), 32'd1);
        check_eq("lat_out_eop", 32'(out_if.eop), 32'd1);
        check_eq("lat_out_data", 32'(out_if.data), 32'h100003);

        // frame-aligned switch: sel flips at beat 2 of an 8-beat input 0 frame
        cycles(2);
        fork
            begin
                int ca;
                for (int i = 0; i < 8; i++) begin
                    send(0, 24'(32'h110000 + i), i == 0, i == 7, 1'b1, ca);
                    if (i == 1) sel = 1'b1;
                end
            end
            begin
                int cb;
                for (int i = 0; i < 6; i++)
                    send(1, 24'(32'h210000 + i), i == 0, i == 5, 1'b0, cb);
            end
        join
        cycles(3);
        check_eq("sw_active_src", 32'(active_src), 32'd1);
        for (int i = 0; i < 3; i++)
            send(1, 24'(32'h220000 + i), i == 0, i == 2, 1'b1, c);

        // realignment: select input 1 with 3 beats of its frame still to come
        sel = 1'b0;
        cycles(4);
        send(1, 24'h230000, 1'b1, 1'b0, 1'b0, c);
        send(1, 24'h230001, 1'b0, 1'b0, 1'b0, c);
        sel = 1'b1;
        cycles(3);
`ifdef STREAM_MUX_STATS_EN
        drop_base = drop_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            send(1, 24'(32'h230002 + i), 1'b0, i == 2, 1'b0, c);
            check_eq("realign_ready", 32'(c), 32'd1);
        end
`ifdef STREAM_MUX_STATS_EN
        check_eq("drop_cnt_delta", 32'(16'(drop_cnt - drop_base)), 32'd3);
`endif
        for (int i = 0; i < 4; i++)
            send(1, 24'(32'h240000 + i), i == 0, i == 3, 1'b1, c);

        // back-pressure for 5 cycles mid-frame
        cycles(2);
        send(1, 24'h250000, 1'b1, 1'b0, 1'b1, c);
        send(1, 24'h250001, 1'b0, 1'b0, 1'b1, c);
        out_if.ready = 1'b0;
        exp_q.push_back({2'b00, 24'h250002});
        put(1, 24'h250002, 1'b0, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_in1_ready", 32'(in1_if.ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_if.valid), 32'd1);
            check_eq("bp_out_data", 32'(out_if.data), 32'h250001);
        end
        @(posedge clk);
        #1;
        out_if.ready = 1'b1;
        wait_acc(1, c);
        check_eq("bp_resume_cycles", 32'(c), 32'd1);
        put(1, 24'h250002, 1'b0, 1'b0, 1'b0);
        send(1, 24'h250003, 1'b0, 1'b1, 1'b1, c);

        // reset at beat 3 of an input 0 frame
        sel = 1'b0;
        cycles(4);
        send(0, 24'h300000, 1'b1, 1'b0, 1'b1, c);
        send(0, 24'h300001, 1'b0, 1'b0, 1'b1, c);
        put(0, 24'h300002, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rstm_in0_ready", 32'(in0_if.ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstm_out_valid", 32'(out_if.valid), 32'd0);
        check_eq("rstm_active_src", 32'(active_src), 32'd0);
        send(0, 24'h300002, 1'b0, 1'b0, 1'b0, c);
        send(0, 24'h300003, 1'b0, 1'b1, 1'b0, c);
        for (int i = 0; i < 3; i++)
            send(0, 24'(32'h310000 + i), i == 0, i == 2, 1'b1, c);

        // single-beat frames on both inputs, sel random every cycle;
        // the source owning cycle k is sel from cycle k-2
        cycles(3);
        for (int k = 0; k < 16; k++) begin
            sh[k] = 1'($urandom_range(0, 1));
            sel = sh[k];
            src = (k >= 2) ? sh[k-2] : 1'b0;
            exp_q.push_back({2'b11, src ? 24'(32'h600000 + k) : 24'(32'h500000 + k)});
            put(0, 24'(32'h500000 + k), 1'b1, 1'b1, 1'b1);
            put(1, 24'(32'h600000 + k), 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            check_eq("sb_in0_ready", 32'(in0_if.ready), 32'd1);
            check_eq("sb_in1_ready", 32'(in1_if.ready), 32'd1);
            @(posedge clk);
            #1;
        end
        put(0, 24'h000000, 1'b0, 1'b0, 1'b0);
        put(1, 24'h000000, 1'b0, 1'b0, 1'b0);

        // drain and report
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
